harris_tensor_scheduler: RTL and testbench

- Aligns the three independent structure-tensor streams (xx, xy, yy) by pixel address.
- Buffers each stream in a small FIFO and issues one matched triple per cycle to the Harris response stage through a valid/ready handshake.
- Discards stale or unmatched entries so that one lost event on any stream cannot deadlock the pipeline.
- Sits between the per-component window accumulators and the Harris response datapath.

---
 rtl/harris_pkg.sv | 35 +++
 rtl/harris_sched_fifo.sv | 60 ++++++
 rtl/harris_tensor_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_harris_tensor_scheduler.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harris_pkg.sv
// Shared definitions for the Harris structure-tensor scheduler.
// Holds the address width, the default datapath width, the scheduler FSM
// state type, default-width FIFO entry layouts and a small address helper.
package harris_pkg;

  localparam int ADDR_W         = 16;
  localparam int DATA_WIDTH_DEF = 23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CMP  = 2'd2
  } sched_state_t;

  // Diagonal terms (xx, yy) are one bit narrower than the cross term (xy).
  typedef struct packed {
    logic [DATA_WIDTH_DEF-2:0] value;
    logic [ADDR_W-1:0]         addr;
  } diag_entry_t;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] value;
    logic [ADDR_W-1:0]         addr;
  } cross_entry_t;

  // Unsigned minimum of three head addresses.
  function automatic logic [ADDR_W-1:0] umin3(input logic [ADDR_W-1:0] a,
                                              input logic [ADDR_W-1:0] b,
                                              input logic [ADDR_W-1:0] c);
    logic [ADDR_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

endpackage

// File: rtl/harris_sched_fifo.sv
// Per-channel entry FIFO for the Harris tensor scheduler.
// Pointers carry one wrap bit; full is registered from the next-state
// pointers so the upstream ready is a clean flop output. A full FIFO never
// accepts, even when it pops in the same cycle.
module harris_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             ready,
  output logic             head_valid,
  output logic             head_last
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr, wptr_nxt, rptr_nxt, level;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full_q, do_push, do_pop;

  assign ready      = !full_q && !flush;
  assign do_push    = push && ready;
  assign head_valid = (wptr != rptr);
  assign do_pop     = pop && head_valid;
  assign level      = wptr - rptr;
  assign head_last  = (level == {{AW{1'b0}}, 1'b1});
  assign rd_data    = mem[rptr[AW-1:0]];
  assign wptr_nxt   = wptr + {{AW{1'b0}}, do_push};
  assign rptr_nxt   = rptr + {{AW{1'b0}}, do_pop};

  // Pointer and registered-full update; flush empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      full_q <= 1'b0;
    end else if (flush) begin
      wptr   <= '0;
      rptr   <= '0;
      full_q <= 1'b0;
    end else begin
      wptr   <= wptr_nxt;
      rptr   <= rptr_nxt;
      full_q <= (wptr_nxt[AW] != rptr_nxt[AW]) &&
                (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
    end
  end

  // Entry storage; data is not reset, only the pointers qualify it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/harris_tensor_scheduler.sv
// Harris structure-tensor scheduler: aligns the xx, xy and yy streams by
// pixel address and issues one matched triple per cycle downstream.
// Unmatched heads are dropped (mismatch: lowest address first; partial sets:
// after TIMEOUT cycles) so a lost event on one stream cannot stall the rest.
// Optional build macro: HARRIS_SCHED_STATS_EN adds saturating issue/drop
// counters as extra outputs.
module harris_tensor_scheduler
  import harris_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid_xx,
  input  logic                  in_valid_xy,
  input  logic                  in_valid_yy,
  output logic                  in_ready_xx,
  output logic                  in_ready_xy,
  output logic                  in_ready_yy,
  input  logic [DATA_WIDTH-2:0] in_value_xx,
  input  logic [DATA_WIDTH-1:0] in_value_xy,
  input  logic [DATA_WIDTH-2:0] in_value_yy,
  input  logic [ADDR_W-1:0]     in_addr_xx,
  input  logic [ADDR_W-1:0]     in_addr_xy,
  input  logic [ADDR_W-1:0]     in_addr_yy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-2:0] out_value_xx,
  output logic [DATA_WIDTH-1:0] out_value_xy,
  output logic [DATA_WIDTH-2:0] out_value_yy,
  output logic [ADDR_W-1:0]     out_addr,
  output logic                  busy
`ifdef HARRIS_SCHED_STATS_EN
  ,
  output logic [31:0]           issue_cnt,
  output logic [15:0]           mismatch_drop_cnt,
  output logic [15:0]           timeout_drop_cnt
`endif
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Entry layouts follow DATA_WIDTH here; the package types describe the
  // default-width layout shared with neighbouring blocks.
  typedef struct packed {
    logic [DATA_WIDTH-2:0] value;
    logic [ADDR_W-1:0]     addr;
  } diag_ent_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] value;
    logic [ADDR_W-1:0]     addr;
  } cross_ent_t;

  diag_ent_t    xx_wr, yy_wr, xx_head, yy_head;
  cross_ent_t   xy_wr, xy_head;
  logic         hv_xx, hv_xy, hv_yy;
  logic         last_xx, last_xy, last_yy;
  logic         pop_xx, pop_xy, pop_yy;
  logic         post_xx, post_xy, post_yy;
  logic         all_hv, any_hv, addr_eq, out_free, tmo_hit, issue;
  logic [ADDR_W-1:0] min_addr;
  sched_state_t state;
  logic [CNT_W-1:0] cnt;

  assign xx_wr = {in_value_xx, in_addr_xx};
  assign xy_wr = {in_value_xy, in_addr_xy};
  assign yy_wr = {in_value_yy, in_addr_yy};

  harris_sched_fifo #(.WIDTH($bits(diag_ent_t)), .DEPTH(DEPTH)) u_fifo_xx (
    .clk(clk), .rst(rst), .flush(flush),
    .push(in_valid_xx), .wr_data(xx_wr), .pop(pop_xx), .rd_data(xx_head),
    .ready(in_ready_xx), .head_valid(hv_xx), .head_last(last_xx)
  );

  harris_sched_fifo #(.WIDTH($bits(cross_ent_t)), .DEPTH(DEPTH)) u_fifo_xy (
    .clk(clk), .rst(rst), .flush(flush),
    .push(in_valid_xy), .wr_data(xy_wr), .pop(pop_xy), .rd_data(xy_head),
    .ready(in_ready_xy), .head_valid(hv_xy), .head_last(last_xy)
  );

  harris_sched_fifo #(.WIDTH($bits(diag_ent_t)), .DEPTH(DEPTH)) u_fifo_yy (
    .clk(clk), .rst(rst), .flush(flush),
    .push(in_valid_yy), .wr_data(yy_wr), .pop(pop_yy), .rd_data(yy_head),
    .ready(in_ready_yy), .head_valid(hv_yy), .head_last(last_yy)
  );

  assign all_hv   = hv_xx && hv_xy && hv_yy;
  assign any_hv   = hv_xx || hv_xy || hv_yy;
  assign addr_eq  = (xx_head.addr == xy_head.addr) && (xy_head.addr == yy_head.addr);
  assign min_addr = umin3(xx_head.addr, xy_head.addr, yy_head.addr);
  assign out_free = !out_valid || out_ready;
  assign tmo_hit  = (cnt == CNT_LAST);

  // Head flags after this cycle's pops; pushes are not counted.
  assign post_xx = hv_xx && !(pop_xx && last_xx);
  assign post_xy = hv_xy && !(pop_xy && last_xy);
  assign post_yy = hv_yy && !(pop_yy && last_yy);

  assign busy = any_hv || out_valid;

  // Pop/issue decisions for the current state; flush suppresses all of them.
  always_comb begin
    pop_xx = 1'b0;
    pop_xy = 1'b0;
    pop_yy = 1'b0;
    issue  = 1'b0;
    if (!flush) begin
      case (state)
        CMP: begin
          if (all_hv) begin
            if (addr_eq) begin
              if (out_free) begin
                issue  = 1'b1;
                pop_xx = 1'b1;
                pop_xy = 1'b1;
                pop_yy = 1'b1;
              end
            end else begin
              pop_xx = (xx_head.addr == min_addr);
              pop_xy = (xy_head.addr == min_addr);
              pop_yy = (yy_head.addr == min_addr);
            end
          end
        end
        WAIT: begin
          if (!all_hv && tmo_hit) begin
            pop_xx = hv_xx;
            pop_xy = hv_xy;
            pop_yy = hv_yy;
          end
        end
        default: ;
      endcase
    end
  end

  // Scheduler FSM and partial-set timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (all_hv)      state <= CMP;
          else if (any_hv) state <= WAIT;
        end
        WAIT: begin
          if (all_hv) begin
            state <= CMP;
            cnt   <= '0;
          end else if (!any_hv || tmo_hit) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CMP: begin
          cnt <= '0;
          if (post_xx && post_xy && post_yy)      state <= CMP;
          else if (post_xx || post_xy || post_yy) state <= WAIT;
          else                                    state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output register: load on issue, hold under backpressure, clear on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_value_xx <= '0;
      out_value_xy <= '0;
      out_value_yy <= '0;
      out_addr     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid    <= 1'b1;
      out_value_xx <= xx_head.value;
      out_value_xy <= xy_head.value;
      out_value_yy <= yy_head.value;
      out_addr     <= xx_head.addr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef HARRIS_SCHED_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] c, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [1:0] pop_num;
  logic       mis_drop, tmo_drop;

  assign pop_num  = 2'(pop_xx) + 2'(pop_xy) + 2'(pop_yy);
  assign mis_drop = !flush && (state == CMP) && all_hv && !addr_eq;
  assign tmo_drop = !flush && (state == WAIT) && !all_hv && tmo_hit;

  // Saturating statistics; cleared only by reset, not by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt         <= '0;
      mismatch_drop_cnt <= '0;
      timeout_drop_cnt  <= '0;
    end else begin
      if (issue)    issue_cnt         <= sat_inc32(issue_cnt);
      if (mis_drop) mismatch_drop_cnt <= sat_add16(mismatch_drop_cnt, pop_num);
      if (tmo_drop) timeout_drop_cnt  <= sat_add16(timeout_drop_cnt, pop_num);
    end
  end
`endif

endmodule

// File: tb/tb_harris_tensor_scheduler.sv
// Self-checking bench for harris_tensor_scheduler (default parameters).
module tb_harris_tensor_scheduler;

  localparam int DW = 23;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          in_valid_xx, in_valid_xy, in_valid_yy;
  logic          in_ready_xx, in_ready_xy, in_ready_yy;
  logic [DW-2:0] in_value_xx, in_value_yy;
  logic [DW-1:0] in_value_xy;
  logic [15:0]   in_addr_xx, in_addr_xy, in_addr_yy;
  logic          out_valid, out_ready;
  logic [DW-2:0] out_value_xx, out_value_yy;
  logic [DW-1:0] out_value_xy;
  logic [15:0]   out_addr;
  logic          busy;
`ifdef HARRIS_SCHED_STATS_EN
  logic [31:0]   issue_cnt;
  logic [15:0]   mismatch_drop_cnt, timeout_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0]   addr;
    logic [DW-2:0] xx;
    logic [DW-1:0] xy;
    logic [DW-2:0] yy;
  } trip_t;

  harris_tensor_scheduler dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid_xx(in_valid_xx), .in_valid_xy(in_valid_xy), .in_valid_yy(in_valid_yy),
    .in_ready_xx(in_ready_xx), .in_ready_xy(in_ready_xy), .in_ready_yy(in_ready_yy),
    .in_value_xx(in_value_xx), .in_value_xy(in_value_xy), .in_value_yy(in_value_yy),
    .in_addr_xx(in_addr_xx), .in_addr_xy(in_addr_xy), .in_addr_yy(in_addr_yy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_value_xx(out_value_xx), .out_value_xy(out_value_xy), .out_value_yy(out_value_yy),
    .out_addr(out_addr), .busy(busy)
`ifdef HARRIS_SCHED_STATS_EN
    , .issue_cnt(issue_cnt), .mismatch_drop_cnt(mismatch_drop_cnt),
    .timeout_drop_cnt(timeout_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0;
    in_valid_xx = 0; in_valid_xy = 0; in_valid_yy = 0;
    in_value_xx = '0; in_value_xy = '0; in_value_yy = '0;
    in_addr_xx = '0; in_addr_xy = '0; in_addr_yy = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    out_ready = 1;
    rst = 1;
    step(); step();
    rst = 0;
    step();
  endtask

  task automatic drive3(input trip_t t);
    in_valid_xx = 1; in_valid_xy = 1; in_valid_yy = 1;
    in_addr_xx = t.addr; in_addr_xy = t.addr; in_addr_yy = t.addr;
    in_value_xx = t.xx; in_value_xy = t.xy; in_value_yy = t.yy;
  endtask

  function automatic trip_t rand_trip(input logic [15:0] a);
    trip_t t;
    t.addr = a;
    t.xx = (DW-1)'($urandom);
    t.xy = DW'($urandom);
    t.yy = (DW-1)'($urandom);
    return t;
  endfunction

  task automatic test_reset();
    idle_inputs();
    out_ready = 1;
    rst = 1;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if ({out_addr, out_value_xx, out_value_xy, out_value_yy} !== '0) begin errors++;
      $display("FAIL reset_out_data got addr %0h xx %0h xy %0h yy %0h want all 0", out_addr, out_value_xx, out_value_xy, out_value_yy); end
    checks++; if ({in_ready_xx, in_ready_xy, in_ready_yy} !== 3'b111) begin errors++;
      $display("FAIL reset_in_ready got %b want 111", {in_ready_xx, in_ready_xy, in_ready_yy}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
`ifdef HARRIS_SCHED_STATS_EN
    checks++; if ({issue_cnt, mismatch_drop_cnt, timeout_drop_cnt} !== '0) begin errors++;
      $display("FAIL reset_stats got %0d %0d %0d want 0 0 0", issue_cnt, mismatch_drop_cnt, timeout_drop_cnt); end
`endif
    step();
    rst = 0;
    step();
  endtask

  task automatic test_aligned();
    trip_t t;
    do_reset();
    t.addr = 16'd5; t.xx = 22'd10; t.xy = 23'd3; t.yy = 22'd7;
    drive3(t);
    step();                       // push edge
    idle_inputs();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL aligned_early1 got %0b want 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL aligned_early2 got %0b want 0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL aligned_valid got %0b want 1", out_valid); end
    checks++; if ({out_addr, out_value_xx, out_value_xy, out_value_yy} !== {16'd5, 22'd10, 23'd3, 22'd7}) begin errors++;
      $display("FAIL aligned_data got addr %0d xx %0d xy %0d yy %0d want 5 10 3 7", out_addr, out_value_xx, out_value_xy, out_value_yy); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL aligned_hold_one got %0b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL aligned_busy got %0b want 0", busy); end
  endtask

  task automatic test_skew();
    int early = 0;
    do_reset();
    in_valid_xx = 1; in_addr_xx = 16'd9; in_value_xx = 22'd100;
    in_valid_yy = 1; in_addr_yy = 16'd9; in_value_yy = 22'd300;
    step();                       // edge 0
    idle_inputs();
    for (int i = 1; i <= 9; i++) begin
      step();
      if (out_valid) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL skew_early got %0d valid cycles want 0", early); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL skew_busy_wait got %0b want 1", busy); end
    in_valid_xy = 1; in_addr_xy = 16'd9; in_value_xy = 23'd200;
    step();                       // edge 10
    idle_inputs();
    step();                       // edge 11
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL skew_edge11 got %0b want 0", out_valid); end
    step();                       // edge 12
    checks++; if ({out_valid, out_addr, out_value_xx, out_value_xy, out_value_yy} !== {1'b1, 16'd9, 22'd100, 23'd200, 22'd300}) begin errors++;
      $display("FAIL skew_issue got v %0b addr %0d xx %0d xy %0d yy %0d want 1 9 100 200 300", out_valid, out_addr, out_value_xx, out_value_xy, out_value_yy); end
    step();
    checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL skew_single got v %0b busy %0b want 0 0", out_valid, busy); end
`ifdef HARRIS_SCHED_STATS_EN
    checks++; if (timeout_drop_cnt !== 16'd0) begin errors++; $display("FAIL skew_no_timeout got %0d want 0", timeout_drop_cnt); end
`endif
  endtask

  task automatic test_mismatch();
    do_reset();
    in_valid_xx = 1; in_addr_xx = 16'd4; in_value_xx = 22'd11;
    in_valid_xy = 1; in_addr_xy = 16'd6; in_value_xy = 23'd22;
    in_valid_yy = 1; in_addr_yy = 16'd6; in_value_yy = 22'd33;
    step();                       // edge 0
    idle_inputs();
    step(); step();               // edge 1 -> CMP, edge 2 drops xx
    checks++; if ({out_valid, busy} !== 2'b01) begin errors++; $display("FAIL mismatch_drop got v %0b busy %0b want 0 1", out_valid, busy); end
    in_valid_xx = 1; in_addr_xx = 16'd6; in_value_xx = 22'd44;
    step();                       // edge 3
    idle_inputs();
    step();                       // edge 4
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mismatch_early got %0b want 0", out_valid); end
    step();                       // edge 5
    checks++; if ({out_valid, out_addr, out_value_xx, out_value_xy, out_value_yy} !== {1'b1, 16'd6, 22'd44, 23'd22, 22'd33}) begin errors++;
      $display("FAIL mismatch_issue got v %0b addr %0d xx %0d xy %0d yy %0d want 1 6 44 22 33", out_valid, out_addr, out_value_xx, out_value_xy, out_value_yy); end
`ifdef HARRIS_SCHED_STATS_EN
    checks++; if (mismatch_drop_cnt !== 16'd1) begin errors++; $display("FAIL mismatch_cnt got %0d want 1", mismatch_drop_cnt); end
    checks++; if (issue_cnt !== 32'd1) begin errors++; $display("FAIL mismatch_issue_cnt got %0d want 1", issue_cnt); end
`endif
    step();
  endtask

  task automatic test_timeout();
    int seen = 0;
    do_reset();
    in_valid_xx = 1; in_addr_xx = 16'd3; in_value_xx = 22'd1;
    step();                       // edge 0
    idle_inputs();
    for (int k = 1; k <= 64; k++) begin
      step();
      if (out_valid) seen++;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_edge64_busy got %0b want 1", busy); end
    step();                       // edge 65: head discarded
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_edge65_busy got %0b want 0", busy); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL timeout_no_valid got %0d valid cycles want 0", seen); end
`ifdef HARRIS_SCHED_STATS_EN
    checks++; if (timeout_drop_cnt !== 16'd1) begin errors++; $display("FAIL timeout_cnt got %0d want 1", timeout_drop_cnt); end
`endif
  endtask

  task automatic test_backpressure();
    trip_t t[5];
    do_reset();
    out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      t[k] = rand_trip(16'(20 + k));
      drive3(t[k]);
      step();
      if (k == 3) begin
        checks++; if ({in_ready_xx, in_ready_xy, in_ready_yy} !== 3'b111) begin errors++;
          $display("FAIL bp_ready_before got %b want 111", {in_ready_xx, in_ready_xy, in_ready_yy}); end
      end
    end
    idle_inputs();
    checks++; if ({in_ready_xx, in_ready_xy, in_ready_yy} !== 3'b000) begin errors++;
      $display("FAIL bp_ready_full got %b want 000", {in_ready_xx, in_ready_xy, in_ready_yy}); end
    for (int h = 0; h < 3; h++) begin
      checks++; if ({out_valid, out_addr, out_value_xx, out_value_xy, out_value_yy} !== {1'b1, t[0].addr, t[0].xx, t[0].xy, t[0].yy}) begin errors++;
        $display("FAIL bp_stall_hold got v %0b addr %0d want 1 %0d", out_valid, out_addr, t[0].addr); end
      step();
    end
    out_ready = 1;
    for (int k = 1; k < 5; k++) begin
      step();
      checks++; if ({out_valid, out_addr, out_value_xx, out_value_xy, out_value_yy} !== {1'b1, t[k].addr, t[k].xx, t[k].xy, t[k].yy}) begin errors++;
        $display("FAIL bp_drain got v %0b addr %0d want 1 %0d", out_valid, out_addr, t[k].addr); end
    end
    step();
    checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_done got v %0b busy %0b want 0 0", out_valid, busy); end
  endtask

  task automatic test_flush();
    int stale = 0;
    do_reset();
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      drive3(rand_trip(16'(40 + k)));
      step();
    end
    idle_inputs();
    checks++; if ({out_valid, busy} !== 2'b11) begin errors++; $display("FAIL flush_pre got v %0b busy %0b want 1 1", out_valid, busy); end
    drive3(rand_trip(16'd99));
    flush = 1;
    #1;
    checks++; if ({in_ready_xx, in_ready_xy, in_ready_yy} !== 3'b000) begin errors++;
      $display("FAIL flush_in_ready got %b want 000", {in_ready_xx, in_ready_xy, in_ready_yy}); end
    step();
    idle_inputs();
    out_ready = 1;
    checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL flush_clear got v %0b busy %0b want 0 0", out_valid, busy); end
    for (int k = 0; k < 6; k++) begin
      step();
      if (out_valid || busy) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL flush_stale got %0d active cycles want 0", stale); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 0;
    for (int k = 0; k < 2; k++) begin
      drive3(rand_trip(16'(60 + k)));
      step();
    end
    idle_inputs();
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %0b want 1", out_valid); end
    #2;
    rst = 1;
    #1;
    checks++; if ({out_valid, busy, out_addr, out_value_xx, out_value_xy, out_value_yy} !== '0) begin errors++;
      $display("FAIL rstmid_clear got v %0b busy %0b addr %0d", out_valid, busy, out_addr); end
    checks++; if ({in_ready_xx, in_ready_xy, in_ready_yy} !== 3'b111) begin errors++;
      $display("FAIL rstmid_ready got %b want 111", {in_ready_xx, in_ready_xy, in_ready_yy}); end
    step();
    rst = 0;
    out_ready = 1;
    step(); step(); step();
    checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL rstmid_after got v %0b busy %0b want 0 0", out_valid, busy); end
  endtask

  // Random lockstep pushes with random backpressure: every pushed triple
  // must come out once, in order, unchanged.
  task automatic test_random_aligned();
    trip_t q[$];
    trip_t e;
    int bad = 0;
    do_reset();
    for (int cyc = 0; cyc < 350; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0) || (cyc >= 300);
      if (out_valid && out_ready) begin
        if (q.size() == 0) bad++;
        else begin
          e = q.pop_front();
          checks++;
          if ({out_addr, out_value_xx, out_value_xy, out_value_yy} !== {e.addr, e.xx, e.xy, e.yy}) begin errors++;
            $display("FAIL rand_aligned got addr %0h xx %0h xy %0h yy %0h want %0h %0h %0h %0h",
                     out_addr, out_value_xx, out_value_xy, out_value_yy, e.addr, e.xx, e.xy, e.yy); end
        end
      end
      if (cyc < 280 && in_ready_xx && in_ready_xy && in_ready_yy && ($urandom_range(0, 1) == 1)) begin
        e = rand_trip(16'($urandom));
        drive3(e);
        q.push_back(e);
      end else begin
        idle_inputs();
      end
      step();
    end
    checks++; if (bad !== 0 || q.size() !== 0) begin errors++;
      $display("FAIL rand_aligned_count got %0d unexpected %0d missing want 0 0", bad, q.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_aligned_idle got busy %0b want 0", busy); end
  endtask

  // Random sorted address lists per channel: expected issues follow
  // "issue when equal, else drop the minimum"; leftovers time out.
  task automatic test_random_mismatch();
    for (int trial = 0; trial < 6; trial++) begin
      logic [15:0]   a_xx[4], a_xy[4], a_yy[4];
      logic [DW-2:0] v_xx[4], v_yy[4];
      logic [DW-1:0] v_xy[4];
      trip_t exp_q[$];
      trip_t e;
      int n, i0, i1, i2, got, bad, cyc;
      logic [15:0] m;
      n = $urandom_range(1, 4);
      for (int k = 0; k < 4; k++) begin
        a_xx[k] = (k == 0) ? 16'($urandom_range(0, 2)) : a_xx[k-1] + 16'($urandom_range(0, 2));
        a_xy[k] = (k == 0) ? 16'($urandom_range(0, 2)) : a_xy[k-1] + 16'($urandom_range(0, 2));
        a_yy[k] = (k == 0) ? 16'($urandom_range(0, 2)) : a_yy[k-1] + 16'($urandom_range(0, 2));
        v_xx[k] = (DW-1)'($urandom); v_xy[k] = DW'($urandom); v_yy[k] = (DW-1)'($urandom);
      end
      i0 = 0; i1 = 0; i2 = 0;
      while (i0 < n && i1 < n && i2 < n) begin
        if (a_xx[i0] == a_xy[i1] && a_xy[i1] == a_yy[i2]) begin
          e.addr = a_xx[i0]; e.xx = v_xx[i0]; e.xy = v_xy[i1]; e.yy = v_yy[i2];
          exp_q.push_back(e);
          i0++; i1++; i2++;
        end else begin
          m = a_xx[i0];
          if (a_xy[i1] < m) m = a_xy[i1];
          if (a_yy[i2] < m) m = a_yy[i2];
          if (a_xx[i0] == m) i0++;
          if (a_xy[i1] == m) i1++;
          if (a_yy[i2] == m) i2++;
        end
      end
      do_reset();
      got = 0; bad = 0; cyc = 0;
      while (cyc < 600) begin
        if (out_valid) begin
          got++;
          if (exp_q.size() == 0) bad++;
          else begin
            e = exp_q.pop_front();
            checks++;
            if ({out_addr, out_value_xx, out_value_xy, out_value_yy} !== {e.addr, e.xx, e.xy, e.yy}) begin errors++;
              $display("FAIL rand_mismatch t%0d got addr %0d xx %0h want addr %0d xx %0h", trial, out_addr, out_value_xx, e.addr, e.xx); end
          end
        end
        if (cyc >= n + 2 && !busy && !out_valid) break;
        if (cyc < n) begin
          in_valid_xx = 1; in_valid_xy = 1; in_valid_yy = 1;
          in_addr_xx = a_xx[cyc]; in_addr_xy = a_xy[cyc]; in_addr_yy = a_yy[cyc];
          in_value_xx = v_xx[cyc]; in_value_xy = v_xy[cyc]; in_value_yy = v_yy[cyc];
        end else begin
          idle_inputs();
        end
        step();
        cyc++;
      end
      checks++; if (bad !== 0 || exp_q.size() !== 0) begin errors++;
        $display("FAIL rand_mismatch_count t%0d got %0d issues (%0d extra, %0d missing)", trial, got, bad, exp_q.size()); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_mismatch_drain t%0d busy %0b after %0d cycles want 0", trial, busy, cyc); end
    end
  endtask

  initial begin
    rst = 1;
    out_ready = 1;
    idle_inputs();
    test_reset();
    test_aligned();
    test_skew();
    test_mismatch();
    test_timeout();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random_aligned();
    test_random_mismatch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
